// File: rtl/edge_pkg.sv
// Shared constants and types for the Sobel front-end feeder.
// Luma weights are fixed-point with an 8-bit fraction.
package edge_pkg;

    localparam logic [15:0] LUMA_R     = 16'd77;
    localparam logic [15:0] LUMA_G     = 16'd150;
    localparam logic [15:0] LUMA_B     = 16'd29;
    localparam int          LUMA_SHIFT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_START = 2'd2,
        ST_BURST = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/rgb2gray_pixel.sv
// RGB888 to 8-bit luma, one registered stage with valid carried alongside.
// The 16-bit accumulator cannot overflow: 256*255 is the maximum sum.
module rgb2gray_pixel
    import edge_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] rgb_i,
    input  logic        valid_i,
    output logic [7:0]  gray_o,
    output logic        valid_o
);

    logic [15:0] w_acc;
    logic [7:0]  r_gray;
    logic        r_valid;

    assign w_acc = LUMA_R * {8'h00, rgb_i[23:16]}
                 + LUMA_G * {8'h00, rgb_i[15:8]}
                 + LUMA_B * {8'h00, rgb_i[7:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gray  <= 8'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_gray <= w_acc[LUMA_SHIFT +: 8];
            end
        end
    end

    assign gray_o  = r_gray;
    assign valid_o = r_valid;

endmodule

// File: rtl/frame_gray_feeder.sv
// Buffers one RGB frame as luma, then replays it to the edge detector as a
// start pulse followed by N gray pixels on consecutive cycles.
module frame_gray_feeder
    import edge_pkg::*;
#(
    parameter int IMG_X_SIZE = 3,
    parameter int IMG_Y_SIZE = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] rgb_data_i,
    input  logic        rgb_valid_i,
    input  logic        rgb_sop_i,
    input  logic        rgb_eop_i,
    output logic        rgb_ready_o,
    output logic        start_o,
    output logic [7:0]  gray_o,
    output logic        gray_valid_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int N  = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int CW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] NPIX = CW'(N);

    feeder_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic [CW-1:0] r_rd_cnt, w_rd_cnt_nxt;
    logic [CW-1:0] r_wr_addr;
    logic [CW-1:0] w_idx;
    logic          r_drain, w_drain_nxt;
    logic          r_err, w_err_nxt;
    logic          r_gray_vld;
    logic [7:0]    r_gray;
    logic          w_rd_en;
    logic          w_beat;
    logic          w_pix_in_vld;
    logic [7:0]    w_pix_gray;
    logic          w_pix_vld;
    logic [7:0]    r_mem [N];

    // Ready is gated by the raw reset so the sink sees 0 throughout reset.
    assign rgb_ready_o  = rst_ni && ((r_state == ST_IDLE) ||
                                     ((r_state == ST_FILL) && !r_drain));
    assign w_beat       = rgb_valid_i && rgb_ready_o;
    assign w_idx        = rgb_sop_i ? '0 : r_wr_cnt;
    assign w_pix_in_vld = w_beat && (rgb_sop_i || (r_state == ST_FILL));

    rgb2gray_pixel u_conv (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .rgb_i   (rgb_data_i),
        .valid_i (w_pix_in_vld),
        .gray_o  (w_pix_gray),
        .valid_o (w_pix_vld)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        w_drain_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if ((r_state == ST_FILL) && r_drain) begin
                    // Last luma lands in the buffer on this edge.
                    w_state_nxt  = ST_START;
                    w_wr_cnt_nxt = '0;
                    w_rd_cnt_nxt = '0;
                end else if (w_pix_in_vld) begin
                    w_err_nxt    = rgb_sop_i && (r_state == ST_FILL);
                    w_wr_cnt_nxt = w_idx + CW'(1);
                    w_state_nxt  = ST_FILL;
                    if (w_idx == LAST) begin
                        if (rgb_eop_i) begin
                            w_drain_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = ST_IDLE;
                            w_err_nxt    = 1'b1;
                            w_wr_cnt_nxt = '0;
                        end
                    end else if (rgb_eop_i) begin
                        w_state_nxt  = ST_IDLE;
                        w_err_nxt    = 1'b1;
                        w_wr_cnt_nxt = '0;
                    end
                end
            end
            ST_START: begin
                // Pixel 0 is fetched while start_o is up, so the burst has no bubble.
                w_rd_en      = 1'b1;
                w_rd_cnt_nxt = r_rd_cnt + CW'(1);
                w_state_nxt  = ST_BURST;
            end
            ST_BURST: begin
                if (r_rd_cnt == NPIX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rd_en      = 1'b1;
                    w_rd_cnt_nxt = r_rd_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_wr_addr  <= '0;
            r_drain    <= 1'b0;
            r_err      <= 1'b0;
            r_gray     <= 8'd0;
            r_gray_vld <= 1'b0;
        end else begin
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_drain    <= w_drain_nxt;
            r_err      <= w_err_nxt;
            r_gray_vld <= w_rd_en;
            if (w_pix_in_vld) begin
                r_wr_addr <= w_idx;
            end
            if (w_rd_en) begin
                r_gray <= r_mem[r_rd_cnt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_pix_vld) begin
            r_mem[r_wr_addr[AW-1:0]] <= w_pix_gray;
        end
    end

    assign start_o      = (r_state == ST_START);
    assign busy_o       = (r_state != ST_IDLE);
    assign gray_o       = r_gray;
    assign gray_valid_o = r_gray_vld;
    assign frame_err_o  = r_err;

endmodule

// File: tb/tb_frame_gray_feeder.sv
// Randomized bench for frame_gray_feeder against a frame-level reference model.
module tb_frame_gray_feeder;

    localparam int XS = 3;
    localparam int YS = 3;
    localparam int N  = XS * YS;

    typedef struct {
        logic [23:0] rgb;
        bit          sop;
        bit          eop;
    } beat_t;

    logic        clk_i;
    logic        rst_ni;
    logic [23:0] rgb_data_i;
    logic        rgb_valid_i;
    logic        rgb_sop_i;
    logic        rgb_eop_i;
    logic        rgb_ready_o;
    logic        start_o;
    logic [7:0]  gray_o;
    logic        gray_valid_o;
    logic        frame_err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    beat_t stim[$];
    int    exp_q[$];
    int    exp_err;
    int    exp_frames;

    int out_q[$];
    int out_cyc_q[$];
    int start_cyc_q[$];
    int acc_cyc_q[$];
    int rise_q[$];
    int err_cyc_q[$];
    int bad_rdy = 0;
    bit ready_d = 1'b0;

    frame_gray_feeder #(.IMG_X_SIZE(XS), .IMG_Y_SIZE(YS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rgb_data_i   (rgb_data_i),
        .rgb_valid_i  (rgb_valid_i),
        .rgb_sop_i    (rgb_sop_i),
        .rgb_eop_i    (rgb_eop_i),
        .rgb_ready_o  (rgb_ready_o),
        .start_o      (start_o),
        .gray_o       (gray_o),
        .gray_valid_o (gray_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (start_o) start_cyc_q.push_back(cyc);
            if (gray_valid_o) begin
                out_q.push_back(int'(gray_o));
                out_cyc_q.push_back(cyc);
            end
            if (frame_err_o) err_cyc_q.push_back(cyc);
            if (rgb_ready_o && (start_o || gray_valid_o)) bad_rdy++;
            if (rgb_ready_o && !ready_d) rise_q.push_back(cyc);
        end
        ready_d = rgb_ready_o;
    end

    function automatic int luma(logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    endfunction

    function automatic logic [23:0] rand_rgb();
        return 24'($urandom);
    endfunction

    task automatic push_beat(input logic [23:0] rgb, input bit sop, input bit eop);
        beat_t b;
        b.rgb = rgb; b.sop = sop; b.eop = eop;
        stim.push_back(b);
    endtask

    task automatic add_frame(input logic [23:0] rgb, input bit rnd);
        for (int i = 0; i < N; i++) push_beat(rnd ? rand_rgb() : rgb, i == 0, i == N - 1);
    endtask

    // Frame rules: sop opens a frame (aborting any open one), beats outside a
    // frame are dropped, a frame is good only if eop arrives exactly on beat N.
    task automatic build_model();
        int cur[$];
        bit active;
        active = 1'b0;
        exp_q.delete(); exp_err = 0; exp_frames = 0;
        foreach (stim[i]) begin
            if (stim[i].sop) begin
                if (active) exp_err++;
                active = 1'b1;
                cur.delete();
            end
            if (active) begin
                cur.push_back(luma(stim[i].rgb));
                if (stim[i].eop || cur.size() == N) begin
                    if (stim[i].eop && cur.size() == N) begin
                        foreach (cur[j]) exp_q.push_back(cur[j]);
                        exp_frames++;
                    end else begin
                        exp_err++;
                    end
                    active = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_mon();
        out_q.delete(); out_cyc_q.delete(); start_cyc_q.delete();
        acc_cyc_q.delete(); rise_q.delete(); err_cyc_q.delete();
        bad_rdy = 0;
    endtask

    // Drives stim; acc_cyc_q gets the mid-cycle stamp before each transfer edge.
    task automatic drive_beats(input int gap_lo, input int gap_hi, output bit to);
        to = 1'b0;
        foreach (stim[i]) begin
            int g;
            int w;
            bit done;
            g = int'($urandom_range(gap_hi, gap_lo));
            repeat (g) begin
                rgb_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            rgb_valid_i = 1'b1;
            rgb_data_i  = stim[i].rgb;
            rgb_sop_i   = stim[i].sop;
            rgb_eop_i   = stim[i].eop;
            w = 0; done = 1'b0;
            while (!done) begin
                @(negedge clk_i);
                if (rgb_ready_o) begin
                    done = 1'b1;
                    acc_cyc_q.push_back(cyc);
                end
                @(posedge clk_i); #1;
                w++;
                if (w > 300) begin
                    to = 1'b1;
                    rgb_valid_i = 1'b0;
                    return;
                end
            end
        end
        rgb_valid_i = 1'b0; rgb_sop_i = 1'b0; rgb_eop_i = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        int w;
        to = 1'b1;
        for (w = 0; w < 400; w++) begin
            @(negedge clk_i);
            if (!busy_o && rgb_ready_o && !gray_valid_o) begin
                to = 1'b0;
                break;
            end
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; rgb_valid_i = 1'b0; rgb_sop_i = 1'b0; rgb_eop_i = 1'b0; rgb_data_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({rgb_ready_o, start_o, gray_o, gray_valid_o, frame_err_o, busy_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {rgb_ready_o, start_o, gray_o, gray_valid_o, frame_err_o, busy_o});
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (rgb_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b required ready=1 busy=0", rgb_ready_o, busy_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_nominal(input int gap, input string name);
        bit to1, to2;
        int c;
        stim.delete();
        add_frame(24'h0A141E, 1'b0);
        build_model(); clear_mon();
        drive_beats(gap, gap, to1);
        wait_idle(to2);
        checks++;
        if (to1 || to2) begin errors++; $display("FAIL %s_timeout: drive=%b idle=%b required 0", name, to1, to2); end
        checks++;
        if (out_q.size() !== N) begin errors++; $display("FAIL %s_count: got %0d pixels required %0d", name, out_q.size(), N); end
        for (int k = 0; k < N && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== 18) begin errors++; $display("FAIL %s_pix%0d: got %0d required 18", name, k, out_q[k]); end
        end
        c = acc_cyc_q.size() > 0 ? acc_cyc_q[acc_cyc_q.size() - 1] : -100;
        checks++;
        if (start_cyc_q.size() !== 1 || start_cyc_q[0] !== c + 2) begin
            errors++;
            $display("FAIL %s_start: %0d pulses, first at %0d, required 1 at %0d", name, start_cyc_q.size(),
                     start_cyc_q.size() > 0 ? start_cyc_q[0] : -1, c + 2);
        end
        for (int k = 0; k < N && k < out_cyc_q.size(); k++) begin
            checks++;
            if (out_cyc_q[k] !== c + 3 + k) begin
                errors++; $display("FAIL %s_pixcyc%0d: got %0d required %0d", name, k, out_cyc_q[k], c + 3 + k);
            end
        end
        checks++;
        if (rise_q.size() !== 1 || rise_q[0] !== c + 3 + N) begin
            errors++;
            $display("FAIL %s_ready_return: %0d rises, first at %0d, required 1 at %0d", name, rise_q.size(),
                     rise_q.size() > 0 ? rise_q[0] : -1, c + 3 + N);
        end
        checks++;
        if (bad_rdy !== 0 || err_cyc_q.size() !== 0) begin
            errors++; $display("FAIL %s_ready_err: ready_in_burst=%0d errs=%0d required 0 0", name, bad_rdy, err_cyc_q.size());
        end
    endtask

    task automatic test_extremes();
        bit to1, to2;
        int lit[3];
        lit[0] = 255; lit[1] = 76; lit[2] = 0;
        stim.delete();
        for (int i = 0; i < N; i++) begin
            logic [23:0] p;
            p = (i % 3 == 0) ? 24'hFFFFFF : ((i % 3 == 1) ? 24'hFF0000 : 24'h000000);
            push_beat(p, i == 0, i == N - 1);
        end
        build_model(); clear_mon();
        drive_beats(0, 2, to1);
        wait_idle(to2);
        checks++;
        if (to1 || to2 || out_q.size() !== N) begin
            errors++; $display("FAIL extremes_count: got %0d pixels (to=%b%b) required %0d", out_q.size(), to1, to2, N);
        end
        for (int k = 0; k < N && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== exp_q[k] || out_q[k] !== lit[k % 3]) begin
                errors++; $display("FAIL extremes_pix%0d: got %0d required %0d", k, out_q[k], lit[k % 3]);
            end
        end
    endtask

    task automatic test_malformed_eop();
        bit to1, to2;
        stim.delete();
        for (int i = 0; i < 5; i++) push_beat(rand_rgb(), i == 0, i == 4);
        build_model(); clear_mon();
        drive_beats(0, 0, to1);
        wait_idle(to2);
        checks++;
        if (to1 || to2 || err_cyc_q.size() !== exp_err || exp_err !== 1) begin
            errors++; $display("FAIL early_eop_err: got %0d pulses (to=%b%b) required %0d", err_cyc_q.size(), to1, to2, exp_err);
        end
        checks++;
        if (err_cyc_q.size() > 0 && acc_cyc_q.size() == 5 && err_cyc_q[0] !== acc_cyc_q[4] + 1) begin
            errors++; $display("FAIL early_eop_errcyc: got %0d required %0d", err_cyc_q[0], acc_cyc_q[4] + 1);
        end
        checks++;
        if (start_cyc_q.size() !== 0 || out_q.size() !== 0 || busy_o !== 1'b0 || rgb_ready_o !== 1'b1) begin
            errors++; $display("FAIL early_eop_idle: starts=%0d pixels=%0d busy=%b ready=%b required 0 0 0 1",
                               start_cyc_q.size(), out_q.size(), busy_o, rgb_ready_o);
        end
    endtask

    task automatic test_sop_restart();
        bit to1, to2;
        stim.delete();
        for (int i = 0; i < 3; i++) push_beat(rand_rgb(), i == 0, 1'b0);
        add_frame('0, 1'b1);
        build_model(); clear_mon();
        drive_beats(0, 1, to1);
        wait_idle(to2);
        checks++;
        if (to1 || to2 || err_cyc_q.size() !== 1 || err_cyc_q[0] !== acc_cyc_q[3] + 1) begin
            errors++; $display("FAIL restart_err: got %0d pulses (to=%b%b) required 1 after beat 4", err_cyc_q.size(), to1, to2);
        end
        checks++;
        if (start_cyc_q.size() !== exp_frames || out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL restart_burst: starts=%0d pixels=%0d required %0d %0d",
                               start_cyc_q.size(), out_q.size(), exp_frames, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL restart_pix%0d: got %0d required %0d", k, out_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_in_burst();
        bit to1, to2;
        int w;
        stim.delete();
        add_frame('0, 1'b1);
        clear_mon();
        drive_beats(0, 0, to1);
        for (w = 0; w < 100 && out_q.size() < 4; w++) begin
            @(posedge clk_i); #1;
        end
        checks++;
        if (to1 || out_q.size() < 4) begin errors++; $display("FAIL rstburst_reach: got %0d pixels required 4", out_q.size()); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({rgb_ready_o, start_o, gray_o, gray_valid_o, frame_err_o, busy_o} !== 13'd0) begin
            errors++;
            $display("FAIL rstburst_async: got %b required all zero",
                     {rgb_ready_o, start_o, gray_o, gray_valid_o, frame_err_o, busy_o});
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (rgb_ready_o !== 1'b1 || busy_o !== 1'b0 || gray_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstburst_idle: ready=%b busy=%b valid=%b required 1 0 0", rgb_ready_o, busy_o, gray_valid_o);
        end
        @(posedge clk_i); #1;
        stim.delete();
        add_frame('0, 1'b1);
        build_model(); clear_mon();
        drive_beats(0, 0, to1);
        wait_idle(to2);
        checks++;
        if (to1 || to2 || out_q.size() !== N || start_cyc_q.size() !== 1) begin
            errors++; $display("FAIL rstburst_fresh: pixels=%0d starts=%0d required %0d 1", out_q.size(), start_cyc_q.size(), N);
        end
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL rstburst_pix%0d: got %0d required %0d", k, out_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        stim.delete();
        add_frame(24'h0A141E, 1'b0);
        add_frame('0, 1'b1);
        build_model(); clear_mon();
        drive_beats(0, 0, to1);
        wait_idle(to2);
        checks++;
        if (to1 || to2 || acc_cyc_q.size() !== 2 * N || rise_q.size() < 1) begin
            errors++; $display("FAIL b2b_accept: beats=%0d rises=%0d (to=%b%b) required %0d >=1",
                               acc_cyc_q.size(), rise_q.size(), to1, to2, 2 * N);
        end else begin
            checks++;
            if (acc_cyc_q[N] !== rise_q[0] || rise_q[0] !== acc_cyc_q[N - 1] + 3 + N) begin
                errors++; $display("FAIL b2b_sop_cycle: sop at %0d ready back at %0d required both %0d",
                                   acc_cyc_q[N], rise_q[0], acc_cyc_q[N - 1] + 3 + N);
            end
        end
        checks++;
        if (start_cyc_q.size() !== 2 || out_cyc_q.size() !== 2 * N) begin
            errors++; $display("FAIL b2b_bursts: starts=%0d pixels=%0d required 2 %0d", start_cyc_q.size(), out_cyc_q.size(), 2 * N);
        end else begin
            checks++;
            if (start_cyc_q[1] <= out_cyc_q[N - 1]) begin
                errors++; $display("FAIL b2b_order: second start at %0d required after %0d", start_cyc_q[1], out_cyc_q[N - 1]);
            end
        end
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_pix%0d: got %0d required %0d", k, out_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_random();
        bit to1, to2;
        for (int it = 0; it < 8; it++) begin
            int kind;
            int p;
            stim.delete();
            kind = int'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) push_beat(rand_rgb(), 1'b0, $urandom_range(1, 0) == 1);
            case (kind)
                1: begin
                    p = int'($urandom_range(N - 2, 1));
                    for (int i = 0; i <= p; i++) push_beat(rand_rgb(), i == 0, i == p);
                end
                2: for (int i = 0; i < N; i++) push_beat(rand_rgb(), i == 0, 1'b0);
                3: begin
                    p = int'($urandom_range(N - 1, 1));
                    for (int i = 0; i < p; i++) push_beat(rand_rgb(), i == 0, 1'b0);
                    add_frame('0, 1'b1);
                end
                default: add_frame('0, 1'b1);
            endcase
            build_model(); clear_mon();
            drive_beats(0, 3, to1);
            wait_idle(to2);
            checks++;
            if (to1 || to2 || err_cyc_q.size() !== exp_err || start_cyc_q.size() !== exp_frames) begin
                errors++; $display("FAIL rand%0d_events: errs=%0d starts=%0d (to=%b%b) required %0d %0d",
                                   it, err_cyc_q.size(), start_cyc_q.size(), to1, to2, exp_err, exp_frames);
            end
            checks++;
            if (out_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d pixels required %0d", it, out_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
                checks++;
                if (out_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_pix%0d: got %0d required %0d", it, k, out_q[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        rgb_valid_i = 1'b0; rgb_sop_i = 1'b0; rgb_eop_i = 1'b0; rgb_data_i = '0;
        test_reset();
        test_nominal(0, "nominal");
        test_extremes();
        test_nominal(1, "gapped");
        test_malformed_eop();
        test_sop_restart();
        test_reset_in_burst();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_gray_feeder.md
# frame_gray_feeder

Upstream feeder for the Sobel edge-detector stage. Accepts an RGB888 frame over an Avalon-ST sink and converts each pixel to 8-bit luma. Stores the whole frame in an internal buffer, then drives the edge detector with its native protocol: one `start` pulse followed by `IMG_X_SIZE*IMG_Y_SIZE` gray pixels on consecutive cycles, with no stalls. This is required because the detector's pixel input has no valid or backpressure.

## Interface
- `IMG_X_SIZE`, default 3: frame width in pixels; must match the detector.
- `IMG_Y_SIZE`, default 3: frame height in pixels; must match the detector.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `rgb_data_i` in 24: Avalon-ST sink data, {R[23:16], G[15:8], B[7:0]}.
- `rgb_valid_i` in 1: sink valid.
- `rgb_sop_i` in 1: start of packet; first pixel of frame.
- `rgb_eop_i` in 1: end of packet; last pixel of frame.
- `rgb_ready_o` out 1: sink ready. Ready latency 0; a beat transfers when `rgb_valid_i && rgb_ready_o`.
- `start_o` out 1: one-cycle start pulse to the detector.
- `gray_o` out 8: gray pixel to the detector's `GrayImage_i`.
- `gray_valid_o` out 1: high in every cycle `gray_o` carries a frame pixel.
- `frame_err_o` out 1: one-cycle pulse when a malformed frame is discarded.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- N = `IMG_X_SIZE*IMG_Y_SIZE`; pixel counter width is `$clog2(N+1)`.
- Luma: gray = (77·R + 150·G + 29·B) >> 8.
  - Use a 16-bit unsigned accumulator; no rounding. Maximum is 65280, so there is no overflow.
  - Registered once (1-cycle conversion pipeline), then written to the buffer at address = pixel index.
- FSM states: IDLE, FILL, START, BURST.
  - IDLE: `rgb_ready_o`=1. A beat with sop writes pixel 0 and moves to FILL, count=1. A beat without sop is consumed and dropped, with no error.
  - FILL: `rgb_ready_o`=1. Each beat writes pixel[count] and increments count.
    - sop beat: restart the frame. The beat becomes pixel 0, count=1, and `frame_err_o` pulses.
    - eop on beat N-1: after the pipeline drains, go to START.
    - eop before beat N-1, or no eop on beat N-1: pulse `frame_err_o` and return to IDLE. The frame is discarded.
    - N=1: sop and eop on the same beat is a legal frame.
  - START: `rgb_ready_o`=0. `start_o`=1 for exactly one cycle, then go to BURST.
  - BURST: `rgb_ready_o`=0. Read the buffer sequentially, one pixel per cycle, with `gray_valid_o`=1. After pixel N-1 is presented, go to IDLE.
- Buffer: N×8 array, one write port (fill) and one synchronous read port (burst). Reads are pre-fetched so no output bubble occurs.
- `gray_o` holds the last presented value outside BURST; it resets to 0.

## Timing
- Reset values: `rgb_ready_o`=0 while `rst_ni`=0, and 1 in the first cycle after release (IDLE). `start_o`, `gray_o`, `gray_valid_o`, `frame_err_o`, `busy_o` all reset to 0. FSM resets to IDLE; counters reset to 0.
- Sink beats may be non-consecutive; the `rgb_valid_i` gaps are ignored.
- Let the last (eop) beat transfer at edge E:
  - luma written at E+1;
  - `start_o` high in the cycle after E+1 (cycle T);
  - pixel k driven in cycle T+1+k, for k=0..N-1;
  - `gray_valid_o` low again in cycle T+1+N;
  - `rgb_ready_o` high again in cycle T+1+N.
- `rgb_ready_o` is low from the cycle after the eop beat until the cycle after the last pixel. No beat is ever accepted during START or BURST.
- Reset asserted mid-operation: all outputs return to reset values immediately (async). Buffer contents are don't-care, and no partial burst resumes.
- `frame_err_o` asserts in the cycle after the offending beat.

## Structure
- Package `edge_pkg` holds:
  - luma coefficients `LUMA_R`=77, `LUMA_G`=150, `LUMA_B`=29, and `LUMA_SHIFT`=8;
  - the FSM state enum `feeder_state_t`.
- Sub-module `rgb2gray_pixel`: combinational multiply-add plus a 1-cycle output register, with a valid passed alongside.
- Buffer is an inferred memory inside `frame_gray_feeder`; no separate module.

## Test plan
- **Nominal 3×3 frame:** nine beats (10,20,30) repeated, sop on the first, eop on the last.
  - Each luma = 18.
  - `start_o` asserts 2 cycles after the eop edge, followed by nine consecutive cycles of `gray_o`=18 with `gray_valid_o`=1.
- **Colour extremes:** pixels alternate white (255,255,255), red (255,0,0), black (0,0,0).
  - Bursted values are 255, 76, 0 in the same order.
- **Gapped input:** `rgb_valid_i` toggles every other cycle.
  - Output burst is identical to the nominal case and gap-free.
  - `rgb_ready_o`=0 throughout START and BURST; no beat is accepted.
- **Malformed frames:**
  - eop on beat 5 of 9: `frame_err_o` one pulse, no `start_o`, back to IDLE.
  - New sop at beat 4: `frame_err_o` pulse, and the following nine-beat frame bursts correctly.
- **Reset in BURST:** drop `rst_ni` after pixel 3.
  - All outputs are 0 asynchronously.
  - After release, IDLE with `rgb_ready_o`=1, and a fresh frame processes normally.
- **Back-to-back frames:** the second frame's sop is presented in the cycle `rgb_ready_o` returns high.
  - It is accepted with no lost beat, and the second start comes only after the first burst completes.
